pipe_reg_skid: RTL and testbench
================================

// Module: pipe_reg_skid
// PURPOSE
//  Parametrised pipeline register stage with valid/ready handshake and 2-entry skid buffer.
//  Generalises the fixed-width enabled register into a WIDTH-bit stage that can stall without
//  losing data and keeps ready registered (no comb path outReady->inReady).
//  Sits between FP datapath stages (unpack -> align -> add -> normalise -> round); adds flush.
// PARAMETERS
//  WIDTH        32   payload width in bits (>=1)
//  RESET_VALUE  '0   value loaded into both data slots on reset
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-high reset
//  flush      in   1      synchronous discard of all held entries
//  inValid    in   1      upstream has data on dataIn
//  inReady    out  1      stage can accept; driven from state flop only
//  dataIn     in   WIDTH  upstream payload
//  outValid   out  1      dataOut holds a valid entry
//  outReady   in   1      downstream accepts dataOut this cycle
//  dataOut    out  WIDTH  head-of-stage payload (main slot)
//  count      out  2      occupancy 0..2
// BEHAVIOUR
//  - One clock (clk); reset asynchronous, active-high. Reset: state EMPTY, main=skid=RESET_VALUE,
//    outValid=0, inReady=1, count=0, dataOut=RESET_VALUE. Reset mid-transfer drops all entries.
//  - push = inValid & inReady; pop = outValid & outReady (both sampled at rising clk).
//  - States: EMPTY (count 0), ONE (main valid, count 1), TWO (main+skid valid, count 2).
//  - outValid = (state!=EMPTY); inReady = (state!=TWO); both decoded from state flops only.
//  - EMPTY: push -> ONE, main<=dataIn. No push -> EMPTY.
//  - ONE: push&pop -> ONE, main<=dataIn; push&!pop -> TWO, skid<=dataIn;
//    !push&pop -> EMPTY; neither -> hold.
//  - TWO: pop -> ONE, main<=skid; no pop -> hold. No push possible (inReady=0).
//  - flush=1: next state EMPTY regardless of push/pop. Data slots keep their values (not cleared).
//    Coincident push is handshaken but discarded. Coincident pop completes normally.
//  - Latency: accepted data visible on dataOut/outValid the cycle after push (1 cycle).
//    Throughput 1 entry/cycle while outReady=1. Strict FIFO order; no loss or duplication.
//  - dataOut/outValid hold stable while outValid & !outReady (except flush/reset).
//  - Upstream holds dataIn stable while inValid & !inReady. dataIn ignored when !push.
//  - X on dataIn without push must not propagate to dataOut.
// STRUCTURE
//  - Shared package fp_pipe_pkg: typedef enum logic [1:0] {EMPTY, ONE, TWO} pipe_state_t;
//    occupancy constants; no WIDTH-dependent types in the package.
//  - One sub-module: register_n #(WIDTH, RESET_VALUE). Enabled register (dataIn, dataOut,
//    writeEnable, reset, clk), instantiated twice (main, skid). Main mux selects dataIn or skid.
//  - State register + next-state logic local; count derived from state.
// TESTING
//  1 Reset: assert reset mid-cycle with TWO held -> outValid=0, inReady=1, count=0,
//    dataOut=RESET_VALUE immediately, without waiting for clk.
//  2 Streaming: outReady=1, push 0x1,0x2,0x3 back-to-back -> dataOut 0x1,0x2,0x3 on
//    consecutive cycles, each 1 cycle after push; count stays 1.
//  3 Stall: outReady=0, push 0xA,0xB -> count=2, inReady=0, dataOut=0xA held.
//    Raise outReady -> 0xA then 0xB, count 2->1->0.
//  4 Back-pressure: inValid=1 with 0xC while TWO -> not accepted; 0xC emerges after 0xA,0xB,
//    no duplicate.
//  5 Flush: TWO state + flush with inValid=1 (0xD) -> next cycle EMPTY, outValid=0, count=0;
//    0xD never appears.
//  6 Random: random inValid/outReady/flush for 10k cycles vs scoreboard queue ->
//    order preserved, inReady never depends on same-cycle outReady, WIDTH=1 and 64 builds pass.

Source files
------------

// File: rtl/fp_pipe_pkg.sv
// fp_pipe_pkg: shared state encoding and occupancy helpers for FP pipeline stages
package fp_pipe_pkg;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} pipe_state_t;
  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;
  function automatic logic [1:0] occupancy(input pipe_state_t s);
    return s == TWO ? OCC_TWO : s == ONE ? OCC_ONE : OCC_EMPTY;
  endfunction
endpackage

// File: rtl/register_n.sv
// register_n: WIDTH-bit enabled register with asynchronous reset to RESET_VALUE
module register_n #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             writeEnable,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] dataOut
);
  logic [WIDTH-1:0] data_q, data_d;
  always_comb data_d = writeEnable ? dataIn : data_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) data_q <= RESET_VALUE;
    else data_q <= data_d;
  assign dataOut = data_q;
endmodule

// File: rtl/pipe_reg_skid.sv
// pipe_reg_skid: valid/ready pipeline stage with 2-entry skid buffer and flush
module pipe_reg_skid
  import fp_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] dataIn,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] dataOut,
  output logic [1:0]       count
);
  pipe_state_t state_q, state_d;
  logic push, pop, main_we, skid_we;
  logic [WIDTH-1:0] main_d, skid_q;
  always_comb begin
    push    = inValid & inReady;
    pop     = outValid & outReady;
    state_d = flush ? EMPTY :
              state_q == EMPTY ? (push ? ONE : EMPTY) :
              state_q == ONE   ? (push & !pop ? TWO : !push & pop ? EMPTY : ONE) :
              (pop ? ONE : TWO);
    // slots are only written on an accepted transfer, so X on an idle dataIn never lands
    main_we = !flush & (state_q == TWO ? pop : push & (state_q == EMPTY | pop));
    skid_we = !flush & state_q == ONE & push & !pop;
    main_d  = state_q == TWO ? skid_q : dataIn;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= EMPTY;
    else state_q <= state_d;
  assign outValid = state_q != EMPTY;
  assign inReady  = state_q != TWO;
  assign count    = occupancy(state_q);
  register_n #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_main (
    .clk(clk), .reset(reset), .writeEnable(main_we), .dataIn(main_d), .dataOut(dataOut)
  );
  register_n #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_skid (
    .clk(clk), .reset(reset), .writeEnable(skid_we), .dataIn(dataIn), .dataOut(skid_q)
  );
endmodule

// File: tb/tb_pipe_reg_skid.sv
// tb_pipe_reg_skid: directed + random scoreboard bench for pipe_reg_skid
module tb_pipe_reg_skid;
  localparam int W = 32;
  localparam logic [W-1:0] RV = 32'h5A5A_0000;
  logic clk = 0, reset = 1, flush = 0, inValid = 0, outReady = 0;
  logic inReady, outValid;
  logic [W-1:0] dataIn = '0, dataOut;
  logic [1:0] count;
  int checks = 0, errors = 0;
  logic [W-1:0] q[$];
  logic [W-1:0] pop_log[$];
  pipe_reg_skid #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .clk(clk), .reset(reset), .flush(flush), .inValid(inValid), .inReady(inReady),
    .dataIn(dataIn), .outValid(outValid), .outReady(outReady), .dataOut(dataOut), .count(count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // scoreboard monitor: model occupancy is the queue depth
  always @(negedge clk) begin
    if (reset) q.delete();
    else begin
      chk("count", 64'(count), 64'(q.size()));
      chk("inReady", 64'(inReady), 64'(q.size() < 2));
      chk("outValid", 64'(outValid), 64'(q.size() != 0));
      if (outValid && outReady && q.size() != 0) begin
        chk("dataOut", 64'(dataOut), 64'(q.pop_front()));
        pop_log.push_back(dataOut);
      end
      if (flush) q.delete();
      else if (inValid && inReady) q.push_back(dataIn);
    end
  end
  task automatic drive(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
    inValid = iv; dataIn = d; outReady = ordy; flush = fl;
    @(posedge clk); #1;
  endtask
  task automatic chk_log(input string name, input logic [W-1:0] exp[$]);
    chk({name, "_len"}, 64'(pop_log.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < pop_log.size(); i++) chk(name, 64'(pop_log[i]), 64'(exp[i]));
    pop_log.delete();
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outValid", 64'(outValid), 0);
    chk("rst_inReady", 64'(inReady), 1);
    chk("rst_count", 64'(count), 0);
    chk("rst_dataOut", 64'(dataOut), 64'(RV));
    reset = 0;
    // streaming
    drive(1, 32'h1, 1, 0);
    chk("stream_lat", 64'(dataOut), 1);
    drive(1, 32'h2, 1, 0);
    chk("stream_d2", 64'(dataOut), 2);
    drive(1, 32'h3, 1, 0);
    chk("stream_d3", 64'(dataOut), 3);
    chk("stream_cnt", 64'(count), 1);
    drive(0, 'x, 1, 0);
    drive(0, '0, 1, 0);
    chk_log("stream", '{32'h1, 32'h2, 32'h3});
    // stall and back-pressure
    drive(1, 32'hA, 0, 0);
    drive(1, 32'hB, 0, 0);
    chk("stall_cnt", 64'(count), 2);
    chk("stall_inReady", 64'(inReady), 0);
    chk("stall_data", 64'(dataOut), 32'hA);
    drive(1, 32'hC, 0, 0);
    chk("bp_hold", 64'(dataOut), 32'hA);
    chk("bp_cnt", 64'(count), 2);
    drive(1, 32'hC, 1, 0);
    chk("bp_pop1", 64'(dataOut), 32'hB);
    chk("bp_cnt1", 64'(count), 1);
    drive(1, 32'hC, 1, 0);
    drive(0, '0, 1, 0);
    drive(0, '0, 1, 0);
    chk("bp_cnt0", 64'(count), 0);
    chk_log("bp", '{32'hA, 32'hB, 32'hC});
    // flush from TWO with a coincident push
    drive(1, 32'h10, 0, 0);
    drive(1, 32'h11, 0, 0);
    drive(1, 32'hD, 0, 1);
    chk("fl_outValid", 64'(outValid), 0);
    chk("fl_count", 64'(count), 0);
    chk("fl_inReady", 64'(inReady), 1);
    drive(0, '0, 1, 0);
    drive(0, '0, 1, 0);
    chk_log("flush", '{});
    // asynchronous reset while holding two entries
    drive(1, 32'h21, 0, 0);
    drive(1, 32'h22, 0, 0);
    chk("pre_rst_cnt", 64'(count), 2);
    inValid = 0;
    #1 reset = 1;
    #1;
    chk("arst_outValid", 64'(outValid), 0);
    chk("arst_inReady", 64'(inReady), 1);
    chk("arst_count", 64'(count), 0);
    chk("arst_dataOut", 64'(dataOut), 64'(RV));
    @(posedge clk); #1 reset = 0;
    pop_log.delete();
    // random traffic
    for (int i = 0; i < 10000; i++)
      if ($urandom_range(1, 0) == 1) drive(1, $urandom, $urandom_range(3, 0) != 0, $urandom_range(31, 0) == 0);
      else drive(0, 'x, $urandom_range(3, 0) != 0, $urandom_range(31, 0) == 0);
    drive(0, '0, 1, 0);
    drive(0, '0, 1, 0);
    drive(0, '0, 1, 0);
    chk("drain_cnt", 64'(count), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
